sudoku_grid_checker: RTL and testbench

//  Parametrised successor to the 4x4 game checker: scans an N x N board (N = BOX*BOX) stored one row per
//  RAM word, checks rows, columns and boxes, and reports win, conflict class and empty-cell count.

---
 rtl/sudoku_pkg.sv | 30 +++
 rtl/sudoku_row_decode.sv | 46 ++++
 rtl/sudoku_grid_checker.sv | 158 +++++++++++++++
 tb/tb_sudoku_grid_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared types, constants and helpers for the sudoku grid checker
package sudoku_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_ROW  = 2'd1;
  localparam logic [1:0] KIND_COL  = 2'd2;
  localparam logic [1:0] KIND_BOX  = 2'd3;

  localparam int DIGIT_LSB = 0;

  // Write-protect flag occupies the top bit of each cell.
  function automatic int wp_bit(input int cell_w);
    return cell_w - 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sudoku_row_decode.sv
// rtl/sudoku_row_decode.sv - one row word to per-cell one-hot digit masks, illegal flags,
// row-duplicate flag and empty-cell count
module sudoku_row_decode
  import sudoku_pkg::*;
#(
  parameter  int BOX     = 2,
  parameter  int DIGIT_W = 4,
  parameter  int CELL_W  = 5,
  localparam int N       = BOX * BOX,
  localparam int RW      = clog2(N + 1)
) (
  input  logic [N*CELL_W-1:0] i_row,
  output logic [N-1:0][N-1:0] o_mask,
  output logic [N-1:0]        o_illegal,
  output logic                o_row_dup,
  output logic [RW-1:0]       o_empty_cnt
);

  logic [N-1:0]       w_seen;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_unused_wp;

  always_comb begin
    o_mask      = '0;
    o_illegal   = '0;
    o_row_dup   = 1'b0;
    o_empty_cnt = '0;
    w_seen      = '0;
    w_digit     = '0;
    w_unused_wp = 1'b0;
    for (int c = 0; c < N; c++) begin
      w_digit     = i_row[c*CELL_W + DIGIT_LSB +: DIGIT_W];
      w_unused_wp = w_unused_wp ^ i_row[c*CELL_W + wp_bit(CELL_W)];
      if (w_digit == '0) begin
        o_empty_cnt = o_empty_cnt + RW'(1);
      end else if (int'(w_digit) > N) begin
        o_illegal[c] = 1'b1;
      end else begin
        o_mask[c] = {{(N-1){1'b0}}, 1'b1} << (w_digit - DIGIT_W'(1));
      end
      if ((w_seen & o_mask[c]) != '0) o_row_dup = 1'b1;
      w_seen = w_seen | o_mask[c];
    end
  end

endmodule

// File: rtl/sudoku_grid_checker.sv
// rtl/sudoku_grid_checker.sv - scans an N x N board from RAM port b and reports win,
// first conflict class and empty-cell count
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter  int BOX        = 2,
  parameter  int DIGIT_W    = 4,
  parameter  int CELL_W     = 5,
  parameter  int RD_LAT     = 1,
  parameter  bit CONTINUOUS = 1'b0,
  localparam int N          = BOX * BOX,
  localparam int AW         = clog2(N),
  localparam int EW         = clog2(N * N + 1),
  localparam int RW         = clog2(N + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic [AW-1:0]       RamAddr,
  output logic                RamRd,
  input  logic [N*CELL_W-1:0] RamDat,
  output logic                busy,
  output logic                scan_done,
  output logic                gameComplete,
  output logic                conflict,
  output logic [1:0]          conflictKind,
  output logic [EW-1:0]       emptyCount
);

  state_t                    r_state, w_next;
  logic [AW-1:0]             r_addr;
  logic [1:0]                r_drain;
  logic [RD_LAT-1:0]         r_tag_vld;
  logic [RD_LAT-1:0][AW-1:0] r_tag_row;
  logic [N-1:0][N-1:0]       r_col_seen, r_box_seen, w_col_nxt, w_box_nxt;
  logic [EW-1:0]             r_empty, w_empty_nxt;
  logic [1:0]                r_kind, w_kind_nxt, w_row_kind;
  logic                      r_scan_done, r_game, r_conf;
  logic [1:0]                r_kind_out;
  logic [EW-1:0]             r_empty_out;

  logic [N-1:0][N-1:0]       w_mask;
  logic [N-1:0]              w_illegal;
  logic                      w_row_dup, w_col_dup, w_box_dup;
  logic [RW-1:0]             w_row_empty;
  logic                      w_last_addr, w_drain_last, w_report_load;
  int                        w_row_idx;

  sudoku_row_decode #(.BOX(BOX), .DIGIT_W(DIGIT_W), .CELL_W(CELL_W)) u_decode (
    .i_row       (RamDat),
    .o_mask      (w_mask),
    .o_illegal   (w_illegal),
    .o_row_dup   (w_row_dup),
    .o_empty_cnt (w_row_empty)
  );

  assign w_last_addr   = (r_addr == AW'(N - 1));
  assign w_drain_last  = (r_drain == 2'(RD_LAT - 1));
  assign w_report_load = (r_state == ST_DRAIN) && w_drain_last;

  assign RamAddr      = r_addr;
  assign RamRd        = (r_state == ST_SCAN);
  assign busy         = (r_state != ST_IDLE);
  assign scan_done    = r_scan_done;
  assign gameComplete = r_game;
  assign conflict     = r_conf;
  assign conflictKind = r_kind_out;
  assign emptyCount   = r_empty_out;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start || CONTINUOUS) w_next = ST_SCAN;
      ST_SCAN:   if (w_last_addr) w_next = ST_DRAIN;
      ST_DRAIN:  if (w_drain_last) w_next = ST_REPORT;
      ST_REPORT: w_next = CONTINUOUS ? ST_SCAN : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Accumulator next-state for the row word whose tag emerges from the read pipeline.
  always_comb begin
    w_col_nxt   = r_col_seen;
    w_box_nxt   = r_box_seen;
    w_empty_nxt = r_empty;
    w_kind_nxt  = r_kind;
    w_col_dup   = 1'b0;
    w_box_dup   = 1'b0;
    w_row_kind  = KIND_NONE;
    w_row_idx   = int'(r_tag_row[RD_LAT-1]);
    if (r_tag_vld[RD_LAT-1]) begin
      for (int c = 0; c < N; c++) begin
        if ((r_col_seen[c] & w_mask[c]) != '0) w_col_dup = 1'b1;
        w_col_nxt[c] = r_col_seen[c] | w_mask[c];
        for (int bb = 0; bb < N; bb++) begin
          if (bb == (w_row_idx / BOX) * BOX + c / BOX) begin
            if ((r_box_seen[bb] & w_mask[c]) != '0) w_box_dup = 1'b1;
            w_box_nxt[bb] = w_box_nxt[bb] | w_mask[c];
          end
        end
      end
      if (w_row_dup)                    w_row_kind = KIND_ROW;
      else if (w_col_dup)               w_row_kind = KIND_COL;
      else if (w_box_dup || |w_illegal) w_row_kind = KIND_BOX;
      w_empty_nxt = r_empty + EW'(w_row_empty);
      if (r_kind == KIND_NONE) w_kind_nxt = w_row_kind;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_drain     <= '0;
      r_tag_vld   <= '0;
      r_tag_row   <= '0;
      r_col_seen  <= '0;
      r_box_seen  <= '0;
      r_empty     <= '0;
      r_kind      <= KIND_NONE;
      r_scan_done <= 1'b0;
      r_game      <= 1'b0;
      r_conf      <= 1'b0;
      r_kind_out  <= KIND_NONE;
      r_empty_out <= '0;
    end else begin
      r_state      <= w_next;
      r_addr       <= (r_state == ST_SCAN && !w_last_addr) ? r_addr + AW'(1) : '0;
      r_drain      <= (r_state == ST_DRAIN) ? r_drain + 2'd1 : 2'd0;
      r_tag_vld[0] <= RamRd;
      r_tag_row[0] <= RamAddr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_row[i] <= r_tag_row[i-1];
      end
      if (r_state == ST_SCAN || r_state == ST_DRAIN) begin
        r_col_seen <= w_col_nxt;
        r_box_seen <= w_box_nxt;
        r_empty    <= w_empty_nxt;
        r_kind     <= w_kind_nxt;
      end else begin
        r_col_seen <= '0;
        r_box_seen <= '0;
        r_empty    <= '0;
        r_kind     <= KIND_NONE;
      end
      // The last row lands in the final drain cycle, so results load from the next-state values.
      r_scan_done <= w_report_load;
      if (w_report_load) begin
        r_game      <= (w_empty_nxt == '0) && (w_kind_nxt == KIND_NONE);
        r_conf      <= (w_kind_nxt != KIND_NONE);
        r_kind_out  <= w_kind_nxt;
        r_empty_out <= w_empty_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// tb/tb_sudoku_grid_checker.sv - scoreboard bench: 4x4 one-shot directed boards plus a
// continuous 9x9 instance
module tb_sudoku_grid_checker;

  typedef struct {
    string      name;
    logic       gc;
    logic       cf;
    logic [1:0] kind;
    int         empty;
    int         cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  logic start;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // 4x4, one-shot, RD_LAT=1
  logic [1:0]  a_addr;
  logic        a_rd, a_busy, a_done, a_gc, a_cf;
  logic [19:0] a_dat;
  logic [1:0]  a_kind;
  logic [4:0]  a_empty;
  logic [19:0] memA [4];

  // 9x9, continuous, RD_LAT=2
  logic [3:0]  b_addr;
  logic        b_rd, b_busy, b_done, b_gc, b_cf;
  logic [44:0] b_dat, b_d1;
  logic [1:0]  b_kind;
  logic [6:0]  b_empty;
  logic [44:0] memB [16];

  exp_t sbq[$];
  exp_t mon_e;
  int   b_pulses = 0;
  int   b_last = 0;
  bit   b_have_last = 1'b0;

  sudoku_grid_checker #(.BOX(2), .DIGIT_W(4), .CELL_W(5), .RD_LAT(1), .CONTINUOUS(1'b0)) dut_a (
    .CLK(CLK), .RST(RST), .start(start), .RamAddr(a_addr), .RamRd(a_rd), .RamDat(a_dat),
    .busy(a_busy), .scan_done(a_done), .gameComplete(a_gc), .conflict(a_cf),
    .conflictKind(a_kind), .emptyCount(a_empty)
  );

  sudoku_grid_checker #(.BOX(3), .DIGIT_W(4), .CELL_W(5), .RD_LAT(2), .CONTINUOUS(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .start(1'b0), .RamAddr(b_addr), .RamRd(b_rd), .RamDat(b_dat),
    .busy(b_busy), .scan_done(b_done), .gameComplete(b_gc), .conflict(b_cf),
    .conflictKind(b_kind), .emptyCount(b_empty)
  );

  always @(posedge CLK) a_dat <= memA[a_addr];
  always @(posedge CLK) begin
    b_d1  <= memB[b_addr];
    b_dat <= b_d1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, a_busy, 0);
    chk({pfx, "_RamRd"}, a_rd, 0);
    chk({pfx, "_RamAddr"}, a_addr, 0);
    chk({pfx, "_scan_done"}, a_done, 0);
    chk({pfx, "_gameComplete"}, a_gc, 0);
    chk({pfx, "_conflict"}, a_cf, 0);
    chk({pfx, "_conflictKind"}, a_kind, 0);
    chk({pfx, "_emptyCount"}, a_empty, 0);
  endtask

  // Board as 16 hex digits, row 0 first; write-protect set on a checkerboard and must be ignored.
  task automatic load_a(input logic [63:0] bd);
    logic [19:0] w;
    for (int r = 0; r < 4; r++) begin
      w = '0;
      for (int c = 0; c < 4; c++) w[c*5 +: 5] = {1'((r + c) % 2), bd[63 - (r*4 + c)*4 -: 4]};
      memA[r] = w;
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got no scan_done within 40 cycles, required one", name);
      sbq.delete();
    end
  endtask

  task automatic run_scan(input string name, input logic [63:0] bd, input logic gc,
                          input logic cf, input logic [1:0] kind, input int empty,
                          input bit extra_start);
    exp_t e;
    load_a(bd);
    @(negedge CLK);
    start   = 1'b1;
    e.name  = name;
    e.gc    = gc;
    e.cf    = cf;
    e.kind  = kind;
    e.empty = empty;
    e.cyc   = cyc + 6;
    sbq.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    if (extra_start) begin
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    wait_empty(name);
  endtask

  always @(negedge CLK) begin
    if (a_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_scan_done: got 1 required 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_gameComplete"}, a_gc, mon_e.gc);
        chk({mon_e.name, "_conflict"}, a_cf, mon_e.cf);
        chk({mon_e.name, "_conflictKind"}, a_kind, mon_e.kind);
        chk({mon_e.name, "_emptyCount"}, a_empty, mon_e.empty);
        chk({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
      end
    end
  end

  always @(negedge CLK) begin
    if (!b_busy) b_have_last = 1'b0;
    if (b_done) begin
      b_pulses++;
      chk("b_gameComplete", b_gc, 1);
      chk("b_conflict", b_cf, 0);
      chk("b_emptyCount", b_empty, 0);
      if (b_have_last) chk("b_period", cyc - b_last, 12);
      b_last      = cyc;
      b_have_last = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) memB[i] = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        memB[r][c*5 +: 5] = {1'b0, 4'(((r*3 + r/3 + c) % 9) + 1)};
    load_a(64'h1234_3412_2143_4321);
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b1;

    run_scan("solved",     64'h1234_3412_2143_4321, 1, 0, 2'd0, 0, 0);
    run_scan("row_dup",    64'h1234_3411_2143_4321, 0, 1, 2'd1, 0, 0);
    run_scan("col_dup",    64'h1234_1423_2143_4321, 0, 1, 2'd2, 0, 0);
    run_scan("box_dup",    64'h1234_2143_3412_4321, 0, 1, 2'd3, 0, 0);
    run_scan("first_kind", 64'h1234_1342_2213_4123, 0, 1, 2'd2, 0, 0);
    run_scan("empty2",     64'h1034_3412_2143_4301, 0, 0, 2'd0, 2, 0);
    run_scan("illegal",    64'h1234_3412_5143_4321, 0, 1, 2'd3, 0, 0);
    run_scan("busy_start", 64'h1234_3412_2143_4321, 1, 0, 2'd0, 0, 1);
    repeat (8) @(negedge CLK);
    chk("busy_start_idle", a_busy, 0);

    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midscan_busy", a_busy, 1);
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("midscan_reset");
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    chk("midscan_idle_after", a_busy, 0);
    chk("b_pulses_min", b_pulses >= 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
